// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//
// Parametrised single-clock synchronous FIFO. It holds the storage array, the
// read/write pointer control and the status flags in one block. Reads are
// registered: data_out and valid_out update on the edge after a read is
// accepted.
//
// Ports
//   clk          in   rising-edge clock for all state
//   reset        in   synchronous reset, active-low; clears pointers, count,
//                     output register, error flags and every memory word
//   wr_en        in   write request
//   data_in      in   [DATA_WIDTH] write data
//   rd_en        in   read request
//   data_out     out  [DATA_WIDTH] registered read data
//   valid_out    out  data_out holds a word popped on the previous edge
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AFULL_TH
//   almost_empty out  count <= AEMPTY_TH
//   count        out  [ADDR_WIDTH+1] occupancy, 0..DEPTH
//   overflow     out  a write request was rejected
//   underflow    out  a read request was rejected
//
// Build option
//   FIFO_STICKY_ERR_EN  when defined, overflow and underflow are sticky and
//                       stay set until reset. When undefined they are
//                       single-cycle pulses.
// -----------------------------------------------------------------------------
module fifo_sync_param #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int AFULL_TH   = 6,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AF_TH_C  = AFULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AE_TH_C  = AEMPTY_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic wr_acc;
  logic rd_acc;
  logic overflow_nxt;
  logic underflow_nxt;

  // Status decode of the registered count
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_TH_C);
  assign almost_empty = (count <= AE_TH_C);

  // A write into a full FIFO is still accepted when a read frees a slot on the
  // same edge. No bypass exists, so a read of an empty FIFO is always rejected.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  assign overflow_nxt  = wr_en & ~wr_acc;
  assign underflow_nxt = rd_en & empty;

  // Storage and write pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_acc) begin
      mem[wr_ptr] <= data_in;
      wr_ptr      <= wr_ptr + PTR_ONE;
    end
  end

  // Registered read port. The array is read with its pre-edge contents, so
  // with rd_ptr == wr_ptr (full, both accepted) the old word is returned.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (rd_acc) begin
      data_out  <= mem[rd_ptr];
      valid_out <= 1'b1;
      rd_ptr    <= rd_ptr + PTR_ONE;
    end else begin
      valid_out <= 1'b0;
    end
  end

  // Occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
`ifdef FIFO_STICKY_ERR_EN
      overflow  <= overflow  | overflow_nxt;
      underflow <= underflow | underflow_nxt;
`else
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
//
// Directed bench for fifo_sync_param at default parameters (12-bit words,
// depth 8, almost_full at 6, almost_empty at 2). Inputs change 1 ns after a
// rising edge; outputs are checked at that same point, i.e. they reflect the
// edge just taken.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

`ifdef FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [11:0] data_in;
  logic        rd_en;
  logic [11:0] data_out;
  logic        valid_out;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  fifo_sync_param #(
    .DATA_WIDTH(12),
    .ADDR_WIDTH(3),
    .AFULL_TH  (6),
    .AEMPTY_TH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;

    // Reset held low for two edges, then released
    tick();
    tick();
    reset = 1'b1;
    chk("rst_count",    count,        0);
    chk("rst_empty",    empty,        1);
    chk("rst_aempty",   almost_empty, 1);
    chk("rst_full",     full,         0);
    chk("rst_afull",    almost_full,  0);
    chk("rst_valid",    valid_out,    0);
    chk("rst_dout",     data_out,     0);
    chk("rst_ovf",      overflow,     0);
    chk("rst_udf",      underflow,    0);

    // Fill with 0x001..0x008
    for (int i = 1; i <= 8; i++) begin
      wr_en   = 1'b1;
      data_in = 12'(i);
      tick();
      chk("fill_count",  count,        i);
      chk("fill_full",   full,         (i == 8));
      chk("fill_afull",  almost_full,  (i >= 6));
      chk("fill_aempty", almost_empty, (i <= 2));
      chk("fill_empty",  empty,        0);
    end

    // Write into a full FIFO is rejected
    wr_en   = 1'b1;
    data_in = 12'hABC;
    tick();
    chk("ovf_pulse", overflow, 1);
    chk("ovf_count", count,    8);
    wr_en = 1'b0;
    tick();
    chk("ovf_after", overflow, STICKY);
    chk("ovf_count2", count,   8);

    // Drain: oldest first, one cycle after each rd_en edge
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      tick();
      chk("drain_valid", valid_out, 1);
      chk("drain_data",  data_out,  i);
      chk("drain_count", count,     8 - i);
    end
    rd_en = 1'b0;
    tick();
    chk("drain_idle_valid", valid_out, 0);
    chk("drain_hold_data",  data_out,  8);
    chk("drain_empty",      empty,     1);
    chk("drain_udf",        underflow, 0);

    // Simultaneous read/write on empty: write taken, read rejected
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = 12'h5A5;
    tick();
    chk("e_sim_udf",   underflow, 1);
    chk("e_sim_valid", valid_out, 0);
    chk("e_sim_count", count,     1);
    wr_en = 1'b0;
    tick();
    chk("e_sim_rd_valid", valid_out, 1);
    chk("e_sim_rd_data",  data_out,  12'h5A5);
    chk("e_sim_rd_count", count,     0);
    chk("e_sim_udf_after", underflow, STICKY);
    rd_en = 1'b0;
    tick();

    // Fill 0x010..0x017 starting from pointer 1, so the pointers wrap
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      data_in = 12'h010 + 12'(i);
      tick();
    end
    chk("wrap_fill_count", count, 8);
    chk("wrap_fill_full",  full,  1);

    // Twelve simultaneous read/writes while full
    for (int i = 0; i < 12; i++) begin
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      data_in = 12'h100 + 12'(i);
      tick();
      chk("fsim_valid", valid_out, 1);
      chk("fsim_data",  data_out,  (i < 8) ? (32'h010 + i) : (32'h100 + i - 8));
      chk("fsim_count", count,     8);
      chk("fsim_ovf",   overflow,  STICKY);
    end

    // Read down to count 5: next words are 0x104..0x106
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      tick();
      chk("pre_rst_data", data_out, 32'h104 + i);
    end
    rd_en = 1'b0;
    tick();
    chk("pre_rst_count", count, 5);

    // Reset mid-stream, with requests active that must be ignored
    reset   = 1'b0;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = 12'h777;
    tick();
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("mrst_count", count,     0);
    chk("mrst_empty", empty,     1);
    chk("mrst_full",  full,      0);
    chk("mrst_valid", valid_out, 0);
    chk("mrst_dout",  data_out,  0);
    chk("mrst_ovf",   overflow,  0);
    chk("mrst_udf",   underflow, 0);

    // Read after reset is rejected
    rd_en = 1'b1;
    tick();
    chk("post_rst_udf",   underflow, 1);
    chk("post_rst_valid", valid_out, 0);
    chk("post_rst_count", count,     0);
    rd_en = 1'b0;
    tick();
    chk("post_rst_udf2", underflow, STICKY);
    tick();
    chk("post_rst_udf3", underflow, STICKY);
    chk("post_rst_ovf",  overflow,  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock synchronous FIFO: storage array, read/write pointer control and status flags in one block.
- Next-generation data buffer for the FIFO path of the project.
- Generalises width and depth. Adds full/empty/almost flags, an occupancy count, a registered read with valid, and overflow/underflow detection.

Parameters:
- DATA_WIDTH, 12, width of each data word.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries (default 8).
- AFULL_TH, 6, almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH-1.
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- wr_en  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- rd_en  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_TH.
- almost_empty  output  1  count <= AEMPTY_TH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  write rejected.
- underflow  output  1  read rejected.

Behaviour:
- Reset: clk and reset are synchronous, active-low.
  - While reset==0 at a rising edge: wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, overflow=0, underflow=0, all memory words cleared to 0.
  - Derived flags after reset: empty=1, full=0, almost_empty=1, almost_full=0.
  - Reset mid-operation discards all contents; no write or read is performed on that edge.
- Write acceptance: wr_acc = wr_en & (~full | rd_acc).
  - On wr_acc: mem[wr_ptr] <= data_in and wr_ptr increments.
- Read acceptance: rd_acc = rd_en & ~empty.
  - On rd_acc: data_out <= mem[rd_ptr], valid_out <= 1, rd_ptr increments.
  - Otherwise valid_out <= 0 and data_out holds its previous value.
  - Read latency: one cycle from the rd_en edge to valid data_out.
- Pointer wrap: pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither occur.
- Status flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count.
- Simultaneous read and write:
  - When full: both are accepted; the read returns the oldest word; count stays DEPTH.
  - When empty: the write is accepted; the read is rejected (no bypass) and underflow is flagged; count becomes 1.
  - When neither full nor empty: both are accepted; count is unchanged.
- Same-address conflict: when rd_ptr==wr_ptr with both accepted (the full case), the read returns the old word, not data_in.
- Error flags (default build): registered single-cycle pulses.
  - overflow <= wr_en & ~wr_acc.
  - underflow <= rd_en & empty.
  - The FIFO state is unchanged by a rejected request.

Optional Feature:
- Macro: FIFO_STICKY_ERR_EN.
- Defined: overflow and underflow are sticky. Once set, each stays 1 until reset==0.
- Undefined: both are one-cycle pulses as described under Behaviour.

Test Plan:
- Reset/basic flags: hold reset=0 for 2 cycles, then release -> count=0, empty=1, almost_empty=1, full=0, valid_out=0, data_out=0.
- Fill/drain (defaults):
  - Write 0x001..0x008 on 8 consecutive cycles -> count steps to 8; almost_full rises when count=6; full=1 at 8.
  - Then read 8 cycles -> data_out=0x001..0x008 in order, each one cycle after rd_en, valid_out=1 each; empty=1 at end.
- Overflow: with full=1, wr_en=1, rd_en=0, data_in=0xABC -> overflow pulses 1 cycle, count stays 8, later reads never return 0xABC.
- Underflow/empty simultaneous:
  - When empty, drive wr_en=1, rd_en=1, data_in=0x5A5 -> underflow=1, valid_out=0, count=1.
  - The next read returns 0x5A5.
- Full simultaneous and wrap: fill 8 words (0x010..0x017), then 12 cycles of wr_en=rd_en=1 with new data 0x100+i -> count stays 8, output order 0x010..0x017 then 0x100.., pointers wrap correctly.
- Reset mid-stream: with count=5, assert reset=0 for one cycle -> count=0, empty=1, valid_out=0; a following read flags underflow.
  - With FIFO_STICKY_ERR_EN defined, underflow stays 1 until the next reset.
